// File: rtl/serial_out_scheduler.sv
// serial_out_scheduler: buffers decoded commands in a small FIFO and routes
// each one, in arrival order, to the serial_out channel named by its select
// field. A start aimed at a channel that is still busy holds the head of the
// queue until that channel reports done (one-shot) or is stopped (repeat).
module serial_out_scheduler #(
    parameter int DATA_BIT   = 32,
    parameter int CH_NUM     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_cmd_valid,
    input  logic [DATA_BIT-1:0]            i_output_pattern,
    input  logic [DATA_BIT-1:0]            i_freq_pattern,
    input  logic [3:0]                     i_sel_out,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic                           i_mode,
    input  logic [CH_NUM-1:0]              i_ch_done_tick,
    output logic [CH_NUM*DATA_BIT-1:0]     o_ch_output_pattern,
    output logic [CH_NUM*DATA_BIT-1:0]     o_ch_freq_pattern,
    output logic [CH_NUM-1:0]              o_ch_mode,
    output logic [CH_NUM-1:0]              o_ch_stop,
    output logic [CH_NUM-1:0]              o_ch_start,
    output logic [CH_NUM-1:0]              o_busy,
    output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count,
    output logic                           o_update_done_tick,
    output logic                           o_drop_tick
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    // Only validated commands reach the FIFO, so the channel index is stored
    // at its natural width rather than the full 4-bit select.
    typedef struct packed {
        logic [DATA_BIT-1:0] outPat;
        logic [DATA_BIT-1:0] freqPat;
        logic [CH_W-1:0]     ch;
        logic                start;
        logic                stop;
        logic                mode;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_DONE
    } state_t;

    cmd_t                   fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr_q;
    logic [PTR_W-1:0]       rdPtr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   drop_q;

    state_t                 state_q;
    logic [CH_NUM*DATA_BIT-1:0] outPat_q;
    logic [CH_NUM*DATA_BIT-1:0] freqPat_q;
    logic [CH_NUM-1:0]      mode_q;
    logic [CH_NUM-1:0]      stop_q;
    logic [CH_NUM-1:0]      start_q;
    logic [CH_NUM-1:0]      busy_q;
    logic [CH_NUM-1:0]      busy_d;
    logic                   updateDone_q;

    cmd_t                   head;
    cmd_t                   wrEntry;
    logic                   selValid;
    logic                   pushEn;
    logic                   popEn;
    logic                   headBusy;

    // Accept a command only when there is room (judged before any pop this
    // cycle) and it names an existing channel; the queue head is read combinationally.
    always_comb begin
        selValid        = ({1'b0, i_sel_out} < 5'(CH_NUM));
        pushEn          = i_cmd_valid && (count_q < CNT_W'(FIFO_DEPTH)) && selValid;
        popEn           = (state_q == S_DONE);
        head            = fifoMem_q[rdPtr_q];
        wrEntry.outPat  = i_output_pattern;
        wrEntry.freqPat = i_freq_pattern;
        wrEntry.ch      = i_sel_out[CH_W-1:0];
        wrEntry.start   = i_start;
        wrEntry.stop    = i_stop;
        wrEntry.mode    = i_mode;
    end

    // Busy status of the channel the head command targets, plus the busy
    // vector after one-shot done ticks have been applied.
    always_comb begin
        headBusy = 1'b0;
        busy_d   = busy_q;
        for (int k = 0; k < CH_NUM; k++) begin
            if (CH_W'(k) == head.ch) begin
                headBusy = busy_q[k];
            end
            if (i_ch_done_tick[k] && !mode_q[k]) begin
                busy_d[k] = 1'b0;
            end
        end
    end

    // Command FIFO storage, pointers, occupancy and the drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= i_cmd_valid && !pushEn;
            if (pushEn) begin
                fifoMem_q[wrPtr_q] <= wrEntry;
                wrPtr_q            <= wrPtr_q + 1'b1;
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Scheduler FSM with the per-channel output registers it drives; an issued
    // start overrides a coincident done tick on the same channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            outPat_q     <= '0;
            freqPat_q    <= '0;
            mode_q       <= '0;
            stop_q       <= '0;
            start_q      <= '0;
            busy_q       <= '0;
            updateDone_q <= 1'b0;
        end else begin
            start_q      <= '0;
            updateDone_q <= 1'b0;
            busy_q       <= busy_d;
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!(head.start && !head.stop && headBusy)) begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    for (int k = 0; k < CH_NUM; k++) begin
                        if (CH_W'(k) == head.ch) begin
                            outPat_q[k*DATA_BIT +: DATA_BIT]  <= head.outPat;
                            freqPat_q[k*DATA_BIT +: DATA_BIT] <= head.freqPat;
                            mode_q[k]                         <= head.mode;
                            if (head.stop) begin
                                stop_q[k] <= 1'b1;
                                busy_q[k] <= 1'b0;
                            end else if (head.start) begin
                                stop_q[k]  <= 1'b0;
                                busy_q[k]  <= 1'b1;
                                start_q[k] <= 1'b1;
                            end
                        end
                    end
                    updateDone_q <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ch_output_pattern = outPat_q;
    assign o_ch_freq_pattern   = freqPat_q;
    assign o_ch_mode           = mode_q;
    assign o_ch_stop           = stop_q;
    assign o_ch_start          = start_q;
    assign o_busy              = busy_q;
    assign o_fifo_count        = count_q;
    assign o_update_done_tick  = updateDone_q;
    assign o_drop_tick         = drop_q;

endmodule

// File: tb/tb_serial_out_scheduler.sv
// Testbench for serial_out_scheduler: directed scenarios followed by random
// commands, checked against a transaction-level model of channel state.
module tb_serial_out_scheduler;

   localparam int DATA_BIT   = 32;
   localparam int CH_NUM     = 4;
   localparam int FIFO_DEPTH = 4;

   logic                       clk;
   logic                       rst_n;
   logic                       i_cmd_valid;
   logic [DATA_BIT-1:0]        i_output_pattern;
   logic [DATA_BIT-1:0]        i_freq_pattern;
   logic [3:0]                 i_sel_out;
   logic                       i_start;
   logic                       i_stop;
   logic                       i_mode;
   logic [CH_NUM-1:0]          i_ch_done_tick;
   logic [CH_NUM*DATA_BIT-1:0] o_ch_output_pattern;
   logic [CH_NUM*DATA_BIT-1:0] o_ch_freq_pattern;
   logic [CH_NUM-1:0]          o_ch_mode;
   logic [CH_NUM-1:0]          o_ch_stop;
   logic [CH_NUM-1:0]          o_ch_start;
   logic [CH_NUM-1:0]          o_busy;
   logic [$clog2(FIFO_DEPTH):0] o_fifo_count;
   logic                       o_update_done_tick;
   logic                       o_drop_tick;

   serial_out_scheduler #(
      .DATA_BIT   (DATA_BIT),
      .CH_NUM     (CH_NUM),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .i_cmd_valid         (i_cmd_valid),
      .i_output_pattern    (i_output_pattern),
      .i_freq_pattern      (i_freq_pattern),
      .i_sel_out           (i_sel_out),
      .i_start             (i_start),
      .i_stop              (i_stop),
      .i_mode              (i_mode),
      .i_ch_done_tick      (i_ch_done_tick),
      .o_ch_output_pattern (o_ch_output_pattern),
      .o_ch_freq_pattern   (o_ch_freq_pattern),
      .o_ch_mode           (o_ch_mode),
      .o_ch_stop           (o_ch_stop),
      .o_ch_start          (o_ch_start),
      .o_busy              (o_busy),
      .o_fifo_count        (o_fifo_count),
      .o_update_done_tick  (o_update_done_tick),
      .o_drop_tick         (o_drop_tick)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DATA_BIT-1:0] patM  [CH_NUM];
   logic [DATA_BIT-1:0] freqM [CH_NUM];
   logic [CH_NUM-1:0]   modeM;
   logic [CH_NUM-1:0]   stopM;
   logic [CH_NUM-1:0]   busyM;

   int                  startCycles;
   logic [CH_NUM-1:0]   startSeen;
   logic                retired;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] pat, input logic [31:0] freq, input int sel,
                                input logic st, input logic sp, input logic md);
      i_cmd_valid      = 1'b1;
      i_output_pattern = pat;
      i_freq_pattern   = freq;
      i_sel_out        = 4'(sel);
      i_start          = st;
      i_stop           = sp;
      i_mode           = md;
      tick();
      i_cmd_valid      = 1'b0;
   endtask

   task automatic pulseDone(input int ch);
      i_ch_done_tick     = '0;
      i_ch_done_tick[ch] = 1'b1;
      tick();
      i_ch_done_tick     = '0;
   endtask

   task automatic modelReset();
      for (int c = 0; c < CH_NUM; c++) begin
         patM[c]  = '0;
         freqM[c] = '0;
      end
      modeM = '0;
      stopM = '0;
      busyM = '0;
   endtask

   task automatic modelDone(input int ch);
      if (busyM[ch] && !modeM[ch]) busyM[ch] = 1'b0;
   endtask

   task automatic modelIssue(input logic [31:0] pat, input logic [31:0] freq, input int ch,
                             input logic st, input logic sp, input logic md);
      patM[ch]  = pat;
      freqM[ch] = freq;
      modeM[ch] = md;
      if (sp) begin
         stopM[ch] = 1'b1;
         busyM[ch] = 1'b0;
      end else if (st) begin
         stopM[ch] = 1'b0;
         busyM[ch] = 1'b1;
      end
   endtask

   task automatic checkAll(input string tag);
      for (int c = 0; c < CH_NUM; c++) begin
         checkOutput($sformatf("%s_pat%0d", tag, c), 64'(o_ch_output_pattern[c*DATA_BIT +: DATA_BIT]), 64'(patM[c]));
         checkOutput($sformatf("%s_freq%0d", tag, c), 64'(o_ch_freq_pattern[c*DATA_BIT +: DATA_BIT]), 64'(freqM[c]));
      end
      checkOutput({tag, "_mode"}, 64'(o_ch_mode), 64'(modeM));
      checkOutput({tag, "_stop"}, 64'(o_ch_stop), 64'(stopM));
      checkOutput({tag, "_busy"}, 64'(o_busy), 64'(busyM));
   endtask

   task automatic sampleStart();
      tick();
      if (o_ch_start != '0) begin
         startCycles++;
         startSeen = o_ch_start;
      end
   endtask

   task automatic waitRetire();
      retired = 1'b0;
      for (int i = 0; i < 20 && !retired; i++) begin
         sampleStart();
         if (o_update_done_tick) retired = 1'b1;
      end
      sampleStart();
   endtask

   // Directed scenarios first, then random traffic against the model.
   initial begin
      int                dropsSeen;
      int                selR;
      int                r;
      logic              st, sp, md, blocked;
      logic [31:0]       pat, freq;
      logic [CH_NUM-1:0] expStart;

      rst_n            = 1'b0;
      i_cmd_valid      = 1'b0;
      i_output_pattern = '0;
      i_freq_pattern   = '0;
      i_sel_out        = '0;
      i_start          = 1'b0;
      i_stop           = 1'b0;
      i_mode           = 1'b0;
      i_ch_done_tick   = '0;
      modelReset();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      $display("[TB] reset state");
      checkAll("reset");
      checkOutput("reset_start", 64'(o_ch_start), 64'd0);
      checkOutput("reset_count", 64'(o_fifo_count), 64'd0);
      checkOutput("reset_update", 64'(o_update_done_tick), 64'd0);
      checkOutput("reset_drop", 64'(o_drop_tick), 64'd0);

      $display("[TB] unblocked start to ch0");
      applyStimulus(32'hA5A5_0F0F, 32'h0000_FFFF, 0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2_count1", 64'(o_fifo_count), 64'd1);
      checkOutput("t2_noDrop", 64'(o_drop_tick), 64'd0);
      tick();
      tick();
      checkOutput("t2_startEarly", 64'(o_ch_start), 64'd0);
      tick();
      checkOutput("t2_start", 64'(o_ch_start), 64'b0001);
      checkOutput("t2_update", 64'(o_update_done_tick), 64'd1);
      modelIssue(32'hA5A5_0F0F, 32'h0000_FFFF, 0, 1'b1, 1'b0, 1'b0);
      checkAll("t2_issue");
      tick();
      checkOutput("t2_startWidth", 64'(o_ch_start), 64'd0);
      checkOutput("t2_updateWidth", 64'(o_update_done_tick), 64'd0);
      checkOutput("t2_count0", 64'(o_fifo_count), 64'd0);
      pulseDone(0);
      modelDone(0);
      checkAll("t2_done");

      $display("[TB] invalid select dropped");
      applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b1, 1'b0, 1'b0);
      checkOutput("sel5_drop", 64'(o_drop_tick), 64'd1);
      checkOutput("sel5_count", 64'(o_fifo_count), 64'd0);
      startCycles = 0;
      repeat (6) sampleStart();
      checkOutput("sel5_dropWidth", 64'(o_drop_tick), 64'd0);
      checkOutput("sel5_noStart", 64'(startCycles), 64'd0);
      checkAll("sel5");

      $display("[TB] head-of-line blocking ch1 then ch2");
      startCycles = 0;
      startSeen   = '0;
      applyStimulus(32'h1111_0001, 32'h2222_0001, 1, 1'b1, 1'b0, 1'b0);
      waitRetire();
      checkOutput("t3_firstRetired", 64'(retired), 64'd1);
      checkOutput("t3_firstStart", 64'(startSeen), 64'b0010);
      modelIssue(32'h1111_0001, 32'h2222_0001, 1, 1'b1, 1'b0, 1'b0);
      applyStimulus(32'h1111_0002, 32'h2222_0002, 1, 1'b1, 1'b0, 1'b0);
      applyStimulus(32'h3333_0002, 32'h4444_0002, 2, 1'b1, 1'b0, 1'b0);
      startCycles = 0;
      repeat (10) sampleStart();
      checkOutput("t3_stalled", 64'(startCycles), 64'd0);
      checkOutput("t3_count2", 64'(o_fifo_count), 64'd2);
      pulseDone(1);
      modelDone(1);
      tick();
      checkOutput("t3_ch1NotYet", 64'(o_ch_start), 64'd0);
      tick();
      checkOutput("t3_ch1Start", 64'(o_ch_start), 64'b0010);
      modelIssue(32'h1111_0002, 32'h2222_0002, 1, 1'b1, 1'b0, 1'b0);
      startCycles = 0;
      repeat (3) sampleStart();
      checkOutput("t3_gap", 64'(startCycles), 64'd0);
      tick();
      checkOutput("t3_ch2Start", 64'(o_ch_start), 64'b0100);
      modelIssue(32'h3333_0002, 32'h4444_0002, 2, 1'b1, 1'b0, 1'b0);
      tick();
      checkAll("t3");
      checkOutput("t3_count0", 64'(o_fifo_count), 64'd0);

      $display("[TB] repeat mode on ch3");
      startCycles = 0;
      startSeen   = '0;
      applyStimulus(32'h5555_0003, 32'h6666_0003, 3, 1'b1, 1'b0, 1'b1);
      waitRetire();
      checkOutput("t4_start", 64'(startSeen), 64'b1000);
      modelIssue(32'h5555_0003, 32'h6666_0003, 3, 1'b1, 1'b0, 1'b1);
      pulseDone(3);
      modelDone(3);
      pulseDone(3);
      modelDone(3);
      checkOutput("t4_stillBusy", 64'(o_busy[3]), 64'd1);
      startCycles = 0;
      applyStimulus(32'h7777_0003, 32'h8888_0003, 3, 1'b1, 1'b1, 1'b0);
      waitRetire();
      checkOutput("t4_stopRetired", 64'(retired), 64'd1);
      checkOutput("t4_stopNoStart", 64'(startCycles), 64'd0);
      modelIssue(32'h7777_0003, 32'h8888_0003, 3, 1'b1, 1'b1, 1'b0);
      checkOutput("t4_stopLevel", 64'(o_ch_stop[3]), 64'd1);
      checkOutput("t4_stopBusy", 64'(o_busy[3]), 64'd0);
      checkAll("t4");

      $display("[TB] start issue coincident with done tick on ch0");
      applyStimulus(32'h9999_0000, 32'hAAAA_0000, 0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      i_ch_done_tick = 4'b0001;
      tick();
      i_ch_done_tick = '0;
      checkOutput("t7_start", 64'(o_ch_start), 64'b0001);
      checkOutput("t7_busy", 64'(o_busy[0]), 64'd1);
      modelDone(0);
      modelIssue(32'h9999_0000, 32'hAAAA_0000, 0, 1'b1, 1'b0, 1'b0);
      tick();
      checkAll("t7");

      $display("[TB] fill FIFO behind busy ch0");
      dropsSeen = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i), 0, 1'b1, 1'b0, 1'b0);
         dropsSeen += int'(o_drop_tick);
      end
      checkOutput("t5_lastDropped", 64'(o_drop_tick), 64'd1);
      checkOutput("t5_dropCount", 64'(dropsSeen), 64'd1);
      checkOutput("t5_full", 64'(o_fifo_count), 64'd4);
      tick();
      checkOutput("t5_dropWidth", 64'(o_drop_tick), 64'd0);
      checkOutput("t5_fullHold", 64'(o_fifo_count), 64'd4);
      checkOutput("t5_noStart", 64'(o_ch_start), 64'd0);

      $display("[TB] reset during blocked check");
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_pat", 64'(|o_ch_output_pattern), 64'd0);
      checkOutput("t6_freq", 64'(|o_ch_freq_pattern), 64'd0);
      checkOutput("t6_mode", 64'(o_ch_mode), 64'd0);
      checkOutput("t6_stop", 64'(o_ch_stop), 64'd0);
      checkOutput("t6_busy", 64'(o_busy), 64'd0);
      checkOutput("t6_count", 64'(o_fifo_count), 64'd0);
      checkOutput("t6_update", 64'(o_update_done_tick), 64'd0);
      checkOutput("t6_drop", 64'(o_drop_tick), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      modelReset();
      startCycles = 0;
      repeat (12) sampleStart();
      checkOutput("t6_noStart", 64'(startCycles), 64'd0);
      checkOutput("t6_countAfter", 64'(o_fifo_count), 64'd0);
      checkAll("t6");

      $display("[TB] random traffic");
      for (int n = 0; n < 40; n++) begin
         selR = $urandom_range(0, CH_NUM + 1);
         st   = 1'($urandom_range(0, 1));
         sp   = 1'($urandom_range(0, 1));
         md   = 1'($urandom_range(0, 1));
         pat  = $urandom;
         freq = $urandom;
         if (selR >= CH_NUM) begin
            applyStimulus(pat, freq, selR, st, sp, md);
            checkOutput("rnd_drop", 64'(o_drop_tick), 64'd1);
            tick();
            checkOutput("rnd_dropCount", 64'(o_fifo_count), 64'd0);
            continue;
         end
         blocked = 1'b0;
         if (st && !sp && busyM[selR]) begin
            if (modeM[selR]) sp = 1'b1;
            else blocked = 1'b1;
         end
         expStart = (st && !sp) ? (CH_NUM'(1) << selR) : '0;
         startCycles = 0;
         startSeen   = '0;
         applyStimulus(pat, freq, selR, st, sp, md);
         if (blocked) begin
            repeat (6) sampleStart();
            pulseDone(selR);
            modelDone(selR);
         end
         waitRetire();
         checkOutput("rnd_retired", 64'(retired), 64'd1);
         checkOutput("rnd_startCycles", 64'(startCycles), 64'(expStart != '0));
         checkOutput("rnd_startChan", 64'(startSeen), 64'(expStart));
         modelIssue(pat, freq, selR, st, sp, md);
         checkAll("rnd");
         checkOutput("rnd_count", 64'(o_fifo_count), 64'd0);
         if ($urandom_range(0, 1) == 1) begin
            r = $urandom_range(0, CH_NUM - 1);
            pulseDone(r);
            modelDone(r);
            checkOutput("rnd_doneBusy", 64'(o_busy), 64'(busyM));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
